// File: rtl/uart_txq_pkg.sv
// Shared types and constants for the UART transmit queue.
package uart_pkg;

  localparam int unsigned DEFAULT_DEPTH = 16;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STROBE,
    S_WAIT_BUSY,
    S_WAIT_IDLE
  } state_e;

endpackage

// File: rtl/uart_txq_if.sv
// Byte-push and transmitter-handshake bundle for uart_txq; master drives pushes and tx_idle.
interface uart_txq_if #(
  parameter int unsigned AW = 4
) ();

  logic          wr_en;
  logic [7:0]    wr_data;
  logic          tx_idle;
  logic [7:0]    tx_data;
  logic          tx_wrsig;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;

  modport master (
    output wr_en, wr_data, tx_idle,
    input  tx_data, tx_wrsig, full, empty, count, overflow
  );

  modport slave (
    input  wr_en, wr_data, tx_idle,
    output tx_data, tx_wrsig, full, empty, count, overflow
  );

endinterface

// File: rtl/uart_txq_sync_fifo.sv
// Single-clock FIFO with reject-when-full pushes and a sticky overflow flag.
module sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4,
  parameter int unsigned DW    = 8
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          push_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          pop_i,
  output logic [DW-1:0] rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o,
  output logic          overflow_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          push_ok, pop_ok;

  // Both flags come from the registered count, so a full queue rejects a
  // push even when a pop frees a slot in the same cycle.
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push_ok) wptr_d = wptr_q + AW'(1);
    if (pop_ok)  rptr_d = rptr_q + AW'(1);
    if (push_ok && !pop_ok)      count_d = count_q + (AW+1)'(1);
    else if (pop_ok && !push_ok) count_d = count_q - (AW+1)'(1);
    if (push_i && full_o) overflow_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o    = mem_q[rptr_q];
  assign count_o    = count_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/uart_txq.sv
// UART transmit queue: FIFO plus drain FSM feeding the transmitter one byte per strobe.
// Define UART_TXQ_CRLF_EN to insert a CR before any LF not already preceded by CR.
module uart_txq
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH    = DEFAULT_DEPTH,
  parameter int unsigned AW       = 4,
  parameter int unsigned BUSY_TMO = 32
) (
  input  logic       clk_i,
  input  logic       reset_i,
  uart_txq_if.slave  bus
);

  localparam int unsigned TmoW = $clog2(BUSY_TMO + 1);

  state_e          state_q, state_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            pop;
  logic [7:0]      head;
  logic            fifo_empty;

`ifdef UART_TXQ_CRLF_EN
  logic            last_cr_q, last_cr_d;
`endif

  sync_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (8)
  ) u_fifo (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .push_i     (bus.wr_en),
    .wdata_i    (bus.wr_data),
    .pop_i      (pop),
    .rdata_o    (head),
    .full_o     (bus.full),
    .empty_o    (fifo_empty),
    .count_o    (bus.count),
    .overflow_o (bus.overflow)
  );

  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    tmo_d     = tmo_q;
    pop       = 1'b0;
`ifdef UART_TXQ_CRLF_EN
    last_cr_d = last_cr_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty && bus.tx_idle) begin
`ifdef UART_TXQ_CRLF_EN
          // The inserted CR leaves the LF at the head for the next pass.
          if (head == ASCII_LF && !last_cr_q) begin
            tx_data_d = ASCII_CR;
          end else begin
            tx_data_d = head;
            pop       = 1'b1;
          end
          last_cr_d = (tx_data_d == ASCII_CR);
`else
          tx_data_d = head;
          pop       = 1'b1;
`endif
          state_d = S_STROBE;
        end
      end
      S_STROBE: begin
        tmo_d   = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        // The timeout covers a transmitter that never visibly goes busy.
        if (!bus.tx_idle || tmo_q == TmoW'(BUSY_TMO - 1)) begin
          state_d = S_WAIT_IDLE;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      S_WAIT_IDLE: begin
        if (bus.tx_idle) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      tx_data_q <= 8'h00;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      tmo_q     <= tmo_d;
    end
  end

`ifdef UART_TXQ_CRLF_EN
  always_ff @(posedge clk_i) begin
    if (reset_i) last_cr_q <= 1'b0;
    else         last_cr_q <= last_cr_d;
  end
`endif

  assign bus.tx_data  = tx_data_q;
  assign bus.tx_wrsig = (state_q == S_STROBE);
  assign bus.empty    = fifo_empty;

endmodule

// File: tb/tb_uart_txq.sv
// Directed self-checking bench for uart_txq with a simple transmitter busy model.
module tb_uart_txq;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_txq_if #(.AW(4)) bus ();

  uart_txq #(
    .DEPTH    (16),
    .AW       (4),
    .BUSY_TMO (32)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic model_on   = 1'b0;
  logic idle_force = 1'b1;
  logic model_idle = 1'b1;
  int   busy_cnt   = 0;

  logic [7:0] byte_log [$];
  int         cyc_log  [$];
  logic [7:0] exp_crlf [$];

  assign bus.tx_idle = model_on ? model_idle : idle_force;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    bus.wr_en   = 1'b1;
    bus.wr_data = b;
    tick(1);
    bus.wr_en   = 1'b0;
  endtask

  task automatic clear_log();
    byte_log.delete();
    cyc_log.delete();
  endtask

  // Transmitter model: goes busy the cycle after a strobe, for 160 cycles.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!model_on) begin
      model_idle <= 1'b1;
      busy_cnt   <= 0;
    end else if (bus.tx_wrsig) begin
      model_idle <= 1'b0;
      busy_cnt   <= 160;
    end else if (busy_cnt > 1) begin
      busy_cnt <= busy_cnt - 1;
    end else begin
      model_idle <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (bus.tx_wrsig === 1'b1) begin
      byte_log.push_back(bus.tx_data);
      cyc_log.push_back(cyc);
      chk("wrsig_while_busy", 32'(bus.tx_idle), 32'd1);
    end
  end

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    reset       = 1'b1;
    tick(3);
    chk("rst_tx_data", 32'(bus.tx_data), 32'h00);
    chk("rst_wrsig", 32'(bus.tx_wrsig), 32'd0);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(S_IDLE));
    reset = 1'b0;

    // Single byte latency: count at N+1, strobe at N+2.
    clear_log();
    push(8'h41);
    chk("t1_count_n1", 32'(bus.count), 32'd1);
    chk("t1_empty_n1", 32'(bus.empty), 32'd0);
    tick(1);
    chk("t1_wrsig_n2", 32'(bus.tx_wrsig), 32'd1);
    chk("t1_data_n2", 32'(bus.tx_data), 32'h41);
    chk("t1_count_n2", 32'(bus.count), 32'd0);
    chk("t1_empty_n2", 32'(bus.empty), 32'd1);
    tick(1);
    chk("t1_wrsig_n3", 32'(bus.tx_wrsig), 32'd0);
    tick(60);
    chk("t1_strobes", 32'(byte_log.size()), 32'd1);

    // Instant transmitter: busy timeout spaces strobes 35 cycles apart.
    clear_log();
    push(8'h55);
    push(8'h56);
    chk("t4_count_pushpop", 32'(bus.count), 32'd1);
    tick(100);
    chk("t4_strobes", 32'(byte_log.size()), 32'd2);
    if (byte_log.size() == 2) begin
      chk("t4_byte0", 32'(byte_log[0]), 32'h55);
      chk("t4_byte1", 32'(byte_log[1]), 32'h56);
      chk("t4_gap", 32'(cyc_log[1] - cyc_log[0]), 32'd35);
    end
    chk("t4_state_idle", 32'(dut.state_q), 32'(S_IDLE));

    // Fill with transmitter busy, then overflow.
    clear_log();
    idle_force = 1'b0;
    for (int i = 1; i <= 16; i++) push(8'(i));
    push(8'h99);
    chk("t2_full", 32'(bus.full), 32'd1);
    chk("t2_count", 32'(bus.count), 32'd16);
    chk("t2_overflow", 32'(bus.overflow), 32'd1);
    chk("t2_empty", 32'(bus.empty), 32'd0);
    // Push in the same cycle as the first pop: still rejected.
    idle_force  = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'hAA;
    tick(1);
    bus.wr_en   = 1'b0;
    chk("t2_count_pop_vs_full", 32'(bus.count), 32'd15);
    chk("t2_full_after_pop", 32'(bus.full), 32'd0);
    tick(620);
    chk("t2_strobes", 32'(byte_log.size()), 32'd16);
    if (byte_log.size() == 16) begin
      for (int i = 0; i < 16; i++) chk("t2_order", 32'(byte_log[i]), 32'(i + 1));
    end
    chk("t2_empty_end", 32'(bus.empty), 32'd1);
    chk("t2_overflow_sticky", 32'(bus.overflow), 32'd1);

    // Realistic transmitter: each strobe waits for tx_idle to return.
    clear_log();
    model_on = 1'b1;
    push(8'h31);
    push(8'h32);
    push(8'h33);
    tick(600);
    chk("t3_strobes", 32'(byte_log.size()), 32'd3);
    if (byte_log.size() == 3) begin
      chk("t3_byte0", 32'(byte_log[0]), 32'h31);
      chk("t3_byte1", 32'(byte_log[1]), 32'h32);
      chk("t3_byte2", 32'(byte_log[2]), 32'h33);
      chk("t3_gap01", 32'(cyc_log[1] - cyc_log[0]), 32'd163);
      chk("t3_gap12", 32'(cyc_log[2] - cyc_log[1]), 32'd163);
    end
    chk("t3_empty", 32'(bus.empty), 32'd1);

    // Reset with 5 bytes queued and the FSM waiting for idle.
    for (int i = 0; i < 6; i++) push(8'(8'h61 + i));
    chk("t5_count_pre", 32'(bus.count), 32'd5);
    chk("t5_state_pre", 32'(dut.state_q), 32'(S_WAIT_IDLE));
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("t5_count", 32'(bus.count), 32'd0);
    chk("t5_empty", 32'(bus.empty), 32'd1);
    chk("t5_overflow", 32'(bus.overflow), 32'd0);
    chk("t5_wrsig", 32'(bus.tx_wrsig), 32'd0);
    chk("t5_tx_data", 32'(bus.tx_data), 32'h00);
    clear_log();
    tick(250);
    chk("t5_no_strobes", 32'(byte_log.size()), 32'd0);

    // Line-ending handling.
    model_on = 1'b0;
    reset    = 1'b1;
    tick(1);
    reset = 1'b0;
    clear_log();
`ifdef UART_TXQ_CRLF_EN
    exp_crlf = '{8'h48, 8'h0D, 8'h0A, 8'h0D, 8'h0A};
`else
    exp_crlf = '{8'h48, 8'h0A, 8'h0D, 8'h0A};
`endif
    push(8'h48);
    push(8'h0A);
    push(8'h0D);
    push(8'h0A);
    tick(250);
    chk("t6_strobes", 32'(byte_log.size()), 32'(exp_crlf.size()));
    if (byte_log.size() == exp_crlf.size()) begin
      for (int i = 0; i < exp_crlf.size(); i++) chk("t6_byte", 32'(byte_log[i]), 32'(exp_crlf[i]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_txq.md
Name: uart_txq

Overview:
- Byte transmit queue that sits directly upstream of the UART transmitter, in place of the single-byte controller path.
- Accepts bytes from the CPU/control side at any rate and buffers them in a FIFO.
- Hands bytes to the transmitter one at a time, using a one-cycle write strobe and the transmitter's idle flag.
- Runs in the 16x-baud clock domain, the same as the transmitter.

Parameters:
- DEPTH, 16: FIFO depth in bytes; must be a power of 2, minimum 2.
- AW, 4: pointer width; must equal log2(DEPTH).
- BUSY_TMO, 32: cycles to wait for tx_idle to fall after a strobe before the queue gives up waiting.

Ports:
- clk  in  1  16x-baud clock
- reset  in  1  synchronous, active-high reset
- wr_en  in  1  push request for wr_data
- wr_data  in  8  byte to enqueue
- tx_idle  in  1  transmitter idle flag; 1 = ready for a new byte
- tx_data  out  8  byte presented to the transmitter; held stable from strobe until the next load
- tx_wrsig  out  1  one-cycle strobe telling the transmitter to start sending tx_data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- count  out  AW+1  current occupancy
- overflow  out  1  sticky; set when a push is dropped

Behaviour:
- Reset values: tx_data=0x00, tx_wrsig=0, full=0, empty=1, count=0, overflow=0, FSM in S_IDLE, both pointers 0.
- Reset mid-transfer clears the queue immediately. A byte already strobed is not recalled.
- Push: accepted when wr_en=1 and full=0. wr_data is written at the write pointer, which increments and wraps modulo DEPTH.
- Push while full: the byte is dropped, count is unchanged, and overflow is set to 1 until reset.
- full is evaluated on the pre-cycle count. A push while full is rejected even if a pop happens in the same cycle.
- Simultaneous push and pop with not-full and not-empty: count is unchanged and both pointers advance.
- A pop happens only in S_IDLE. It reads the byte at the read pointer into tx_data; the read pointer increments and wraps.
- Drain FSM states and transitions:
  - S_IDLE: if empty=0 and tx_idle=1, pop and go to S_STROBE; otherwise stay.
  - S_STROBE: drive tx_wrsig=1 for exactly this cycle, then go to S_WAIT_BUSY.
  - S_WAIT_BUSY: on tx_idle=0, go to S_WAIT_IDLE. If BUSY_TMO cycles pass with tx_idle=1, also go to S_WAIT_IDLE; this covers a transmitter that finishes instantly.
  - S_WAIT_IDLE: on tx_idle=1, go to S_IDLE.
- Latency: a push at cycle N into an empty queue, with the FSM in S_IDLE and tx_idle=1, gives count=1 at N+1, the pop at N+1, and tx_wrsig=1 at N+2.
- Pushing into an empty queue and popping in the same cycle is impossible by construction, since a pop requires empty=0.
- Back-to-back bytes: at least 3 cycles separate consecutive strobes, plus the transmitter's busy time.
- tx_wrsig is never asserted while tx_idle=0.

Optional Feature:
- Macro: UART_TXQ_CRLF_EN.
- With the macro defined:
  - If the head byte is 0x0A and the previously strobed byte was not 0x0D, the FSM first sends 0x0D without popping, then sends the 0x0A normally.
  - A 1-bit last_cr register tracks whether the last strobed byte was 0x0D; it is cleared by reset.
  - count counts stored bytes only; the inserted CR does not count.
- Without the macro, bytes are sent verbatim.

Decomposition:
- uart_pkg holds:
  - the FSM state encoding: S_IDLE, S_STROBE, S_WAIT_BUSY, S_WAIT_IDLE;
  - the constants ASCII_CR=8'h0D and ASCII_LF=8'h0A;
  - the default DEPTH.
- Sub-module sync_fifo (DEPTH, AW, 8-bit):
  - contains the storage array, pointers, count, full/empty and the overflow flag;
  - has push/pop ports with the reject-when-full rule above.
- uart_txq = sync_fifo + drain FSM + CRLF logic.

Test Plan:
- After reset, push 0x41 with tx_idle=1 -> tx_wrsig pulses 2 cycles later with tx_data=0x41; count returns to 0; empty=1.
- Push 0x01..0x10 (16 bytes) with tx_idle=0 held, then push 0x99 -> full=1, count=16, overflow=1, 0x99 never appears on tx_data.
- Transmitter model drops tx_idle 1 cycle after each strobe and holds it low 160 cycles; push 0x31,0x32,0x33 -> three strobes in order, each only after tx_idle returns high.
- tx_idle held at 1 constantly (instant transmitter), push 0x55 -> S_WAIT_BUSY times out after 32 cycles and the FSM returns to S_IDLE with no second strobe.
- Assert reset while 5 bytes are queued and the FSM is in S_WAIT_IDLE -> next cycle count=0, empty=1, overflow=0, tx_wrsig=0, no further strobes.
- With UART_TXQ_CRLF_EN defined, push 0x48,0x0A,0x0D,0x0A -> strobes carry 0x48,0x0D,0x0A,0x0D,0x0A. Without the macro -> 0x48,0x0A,0x0D,0x0A.
